regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined core, generalising the existing 2-read/1-write register file. Adds a configurable number of read ports, a second write port for late-returning loads, synchronous reset clearing, and a per-register busy scoreboard set at issue and cleared at writeback. Sits between ID (reads, issue), WB (port 0 write) and the load-return path (port 1 write); the hazard unit consumes the busy outputs to stall.

---
 rtl/regfile_scoreboard.sv | 84 ++++++++
 tb/tb_regfile_scoreboard.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a second (load-return) write port,
// same-cycle write bypass and a per-register busy scoreboard for the hazard unit.
module regfile_scoreboard #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   parameter  int NRD   = 2,
   localparam int AW    = $clog2(NREGS),
   localparam int CW    = $clog2(NREGS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_en,
   input  logic [AW-1:0]       wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                ld_en,
   input  logic [AW-1:0]       ld_addr,
   input  logic [XLEN-1:0]     ld_data,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   output logic [CW-1:0]       busy_count
);

   logic [XLEN-1:0]  r_mem [NREGS];
   logic [NREGS-1:0] r_busy;
   logic [CW-1:0]    r_busy_count;
   logic [NREGS-1:0] w_busy_next;
   logic [CW-1:0]    w_count_next;

   // A new producer issued this cycle overrides a completing write to the same register.
   always_comb begin
      w_busy_next  = '0;
      w_count_next = '0;
      for (int j = 1; j < NREGS; j++) begin
         if (iss_en && iss_addr == AW'(j))
            w_busy_next[j] = 1'b1;
         else if ((wb_en && wb_addr == AW'(j)) || (ld_en && ld_addr == AW'(j)))
            w_busy_next[j] = 1'b0;
         else
            w_busy_next[j] = r_busy[j];
         w_count_next = w_count_next + CW'(w_busy_next[j]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is cleared by reset, so it must live in flops rather than a RAM macro.
         for (int j = 0; j < NREGS; j++)
            r_mem[j] <= '0;
         r_busy       <= '0;
         r_busy_count <= '0;
      end else begin
         // NOTE: both writes are non-blocking; the later one (ld) wins on an address collision.
         if (wb_en && wb_addr != '0)
            r_mem[wb_addr] <= wb_data;
         if (ld_en && ld_addr != '0)
            r_mem[ld_addr] <= ld_data;
         r_busy       <= w_busy_next;
         r_busy_count <= w_count_next;
      end
   end

   assign busy_count = r_busy_count;

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_ld_hit;
      logic          w_wb_hit;

      assign w_addr   = rd_addr[g*AW +: AW];
      assign w_ld_hit = !rst && ld_en && ld_addr == w_addr;
      assign w_wb_hit = !rst && wb_en && wb_addr == w_addr;

      // Bypass suppressed during reset: the write being presented is about to be lost.
      assign rd_data[g*XLEN +: XLEN] = (w_addr == '0) ? '0      :
                                       w_ld_hit       ? ld_data :
                                       w_wb_hit       ? wb_data :
                                                        r_mem[w_addr];
      assign rd_busy[g] = r_busy[w_addr] & ~(w_ld_hit | w_wb_hit);
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expected read-port state
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_regfile_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;
   localparam int CW    = 6;

   typedef struct {
      int          cyc;
      string       name;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] busy;
      logic [31:0] cnt;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst;
   logic                wb_en, ld_en, iss_en;
   logic [AW-1:0]       wb_addr, ld_addr, iss_addr;
   logic [XLEN-1:0]     wb_data, ld_data;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [CW-1:0]       busy_count;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk(clk), .rst(rst),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .iss_en(iss_en), .iss_addr(iss_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .busy_count(busy_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic expect_now(input string name, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] busy, input int cnt);
      exp_t e;
      e.cyc  = cyc;
      e.name = name;
      e.d0   = d0;
      e.d1   = d1;
      e.busy = 32'(busy);
      e.cnt  = 32'(cnt);
      sb.push_back(e);
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {a1[AW-1:0], a0[AW-1:0]};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      wb_en  = 1'b0;
      ld_en  = 1'b0;
      iss_en = 1'b0;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         check({mon_e.name, ".d0"},   rd_data[31:0],     mon_e.d0);
         check({mon_e.name, ".d1"},   rd_data[63:32],    mon_e.d1);
         check({mon_e.name, ".busy"}, 32'(rd_busy),      mon_e.busy);
         check({mon_e.name, ".cnt"},  32'(busy_count),   mon_e.cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      wb_en = 1'b0; ld_en = 1'b0; iss_en = 1'b0;
      wb_addr = '0; ld_addr = '0; iss_addr = '0;
      wb_data = '0; ld_data = '0; rd_addr = '0;
      step();
      rst = 1'b0;

      for (int a = 0; a < NREGS; a++) begin
         set_rd(a, NREGS - 1 - a);
         expect_now("rst_read", 32'h0, 32'h0, 2'b00, 0);
         step();
      end

      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      ld_en = 1'b1; ld_addr = 5'd5; ld_data = 32'h12345678;
      set_rd(5, 5);
      expect_now("ld_wins_byp", 32'h12345678, 32'h12345678, 2'b00, 0);
      step();
      set_rd(5, 0);
      expect_now("ld_wins_arr", 32'h12345678, 32'h0, 2'b00, 0);
      step();

      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      ld_en = 1'b1; ld_addr = 5'd0; ld_data = 32'hFFFFFFFF;
      iss_en = 1'b1; iss_addr = 5'd0;
      set_rd(0, 0);
      expect_now("x0_byp", 32'h0, 32'h0, 2'b00, 0);
      step();
      expect_now("x0_after", 32'h0, 32'h0, 2'b00, 0);
      step();

      iss_en = 1'b1; iss_addr = 5'd7;
      set_rd(7, 5);
      expect_now("iss7", 32'h0, 32'h12345678, 2'b00, 0);
      step();
      repeat (3) begin
         set_rd(7, 5);
         expect_now("busy7", 32'h0, 32'h12345678, 2'b01, 1);
         step();
      end
      ld_en = 1'b1; ld_addr = 5'd7; ld_data = 32'h000000A5;
      set_rd(7, 7);
      expect_now("ld7_byp", 32'hA5, 32'hA5, 2'b00, 1);
      step();
      set_rd(5, 7);
      expect_now("ld7_after", 32'h12345678, 32'hA5, 2'b00, 0);
      step();

      iss_en = 1'b1; iss_addr = 5'd9;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000099;
      set_rd(9, 9);
      expect_now("iss_wb9", 32'h99, 32'h99, 2'b00, 0);
      step();
      iss_en = 1'b1; iss_addr = 5'd9;
      set_rd(7, 9);
      expect_now("x9_busy", 32'hA5, 32'h99, 2'b10, 1);
      step();
      set_rd(9, 9);
      expect_now("x9_reissue", 32'h99, 32'h99, 2'b11, 1);
      step();
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h00000100;
      set_rd(9, 0);
      expect_now("wb9_clr", 32'h100, 32'h0, 2'b00, 1);
      step();
      set_rd(9, 9);
      expect_now("wb9_after", 32'h100, 32'h100, 2'b00, 0);
      step();

      for (int k = 1; k < NREGS; k++) begin
         iss_en = 1'b1; iss_addr = AW'(k);
         set_rd(3, 31);
         expect_now("fill", 32'h0, 32'h0, {1'b0, (k > 3)}, k - 1);
         step();
      end
      set_rd(3, 31);
      expect_now("fill_done", 32'h0, 32'h0, 2'b11, 31);
      step();

      rst = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h00000333;
      ld_en = 1'b1; ld_addr = 5'd5; ld_data = 32'h00000555;
      iss_en = 1'b1; iss_addr = 5'd3;
      set_rd(3, 5);
      expect_now("rst_nobyp", 32'h0, 32'h12345678, 2'b11, 31);
      step();
      rst = 1'b0;
      set_rd(3, 5);
      expect_now("rst_after", 32'h0, 32'h0, 2'b00, 0);
      step();
      set_rd(9, 31);
      expect_now("rst_after2", 32'h0, 32'h0, 2'b00, 0);
      step();

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
